// File: rtl/csr_rmw_sequencer_if.sv
// Bundle of the sequencer's request, CSR-file, response and status signals.
// master: issue/commit/CSR-file side (drives requests, read data, rsp_ready, fpu_pending).
// slave:  the sequencer (drives req_ready, CSR strobes, response, busy, stall_count).
interface csr_rmw_sequencer_if #(
  parameter int NUM_WARPS     = 4,
  parameter int NW_BITS       = 2,
  parameter int UUID_BITS     = 44,
  parameter int CSR_ADDR_BITS = 12,
  parameter int PERF_CTR_BITS = 44
);
  // request from issue
  logic                     req_valid;
  logic                     req_ready;
  logic [UUID_BITS-1:0]     req_uuid;
  logic [NW_BITS-1:0]       req_wid;
  logic [CSR_ADDR_BITS-1:0] req_addr;
  logic [1:0]               req_op;
  logic [31:0]              req_src;
  logic                     req_src_zero;
  logic [4:0]               req_rd;
  logic [NUM_WARPS-1:0]     fpu_pending;
  // CSR data file
  logic                     csr_read_enable;
  logic [UUID_BITS-1:0]     csr_read_uuid;
  logic [CSR_ADDR_BITS-1:0] csr_read_addr;
  logic [NW_BITS-1:0]       csr_read_wid;
  logic [31:0]              csr_read_data;
  logic                     csr_write_enable;
  logic [UUID_BITS-1:0]     csr_write_uuid;
  logic [CSR_ADDR_BITS-1:0] csr_write_addr;
  logic [NW_BITS-1:0]       csr_write_wid;
  logic [31:0]              csr_write_data;
  // response to commit
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [UUID_BITS-1:0]     rsp_uuid;
  logic [NW_BITS-1:0]       rsp_wid;
  logic [4:0]               rsp_rd;
  logic [31:0]              rsp_data;
  // status
  logic                     busy;
  logic [PERF_CTR_BITS-1:0] stall_count;

  modport master (
    output req_valid, req_uuid, req_wid, req_addr, req_op, req_src, req_src_zero, req_rd,
    output fpu_pending, csr_read_data, rsp_ready,
    input  req_ready, csr_read_enable, csr_read_uuid, csr_read_addr, csr_read_wid,
    input  csr_write_enable, csr_write_uuid, csr_write_addr, csr_write_wid, csr_write_data,
    input  rsp_valid, rsp_uuid, rsp_wid, rsp_rd, rsp_data, busy, stall_count
  );

  modport slave (
    input  req_valid, req_uuid, req_wid, req_addr, req_op, req_src, req_src_zero, req_rd,
    input  fpu_pending, csr_read_data, rsp_ready,
    output req_ready, csr_read_enable, csr_read_uuid, csr_read_addr, csr_read_wid,
    output csr_write_enable, csr_write_uuid, csr_write_addr, csr_write_wid, csr_write_data,
    output rsp_valid, rsp_uuid, rsp_wid, rsp_rd, rsp_data, busy, stall_count
  );
endinterface

// File: rtl/csr_rmw_sequencer.sv
// CSR read-modify-write sequencer (CSRRW/CSRRS/CSRRC) between issue and the CSR data file.
// Latency: accept -> rsp_valid in 2 cycles (no write) or 3 cycles (with write); one request in flight.
// Backpressure: req_ready low while busy or while an FP-flag CSR hits a warp with FPU ops pending;
// the response is held stable until rsp_ready.
// Ports: clk, reset (async, active-high), bus (slave modport: request, CSR file, response, status).
module csr_rmw_sequencer #(
  parameter int NUM_WARPS     = 4,
  parameter int NW_BITS       = 2,
  parameter int UUID_BITS     = 44,
  parameter int CSR_ADDR_BITS = 12,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                  clk,
  input  logic                  reset,
  csr_rmw_sequencer_if.slave    bus
);

  localparam logic [CSR_ADDR_BITS-1:0] ADDR_FFLAGS = CSR_ADDR_BITS'(12'h001);
  localparam logic [CSR_ADDR_BITS-1:0] ADDR_FCSR   = CSR_ADDR_BITS'(12'h003);

  localparam logic [1:0] OP_RO = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t                   state_q;
  logic [UUID_BITS-1:0]     uuid_q;
  logic [NW_BITS-1:0]       wid_q;
  logic [CSR_ADDR_BITS-1:0] addr_q;
  logic [1:0]               op_q;
  logic [31:0]              src_q;
  logic                     src_zero_q;
  logic [4:0]               rd_q;
  logic [31:0]              old_q;
  logic [31:0]              new_q;
  logic                     rd_en_q;
  logic                     wr_en_q;
  logic                     rsp_vld_q;
  logic [PERF_CTR_BITS-1:0] stall_q;

  logic        hz;
  logic        req_ready_w;
  logic [31:0] new_d;
  logic        do_write_d;
  logic [PERF_CTR_BITS-1:0] stall_d;

  // FRM (0x002) is deliberately absent: only the flag-carrying CSRs race with in-flight FPU ops.
  assign hz = ((bus.req_addr == ADDR_FFLAGS) || (bus.req_addr == ADDR_FCSR))
              && bus.fpu_pending[bus.req_wid];

  // Combinational so a dropping fpu_pending releases a stalled request in the same cycle.
  assign req_ready_w = (state_q == S_IDLE) && !hz;

  always_comb begin
    new_d = bus.csr_read_data;
    case (op_q)
      OP_RW:   new_d = src_q;
      OP_RS:   new_d = bus.csr_read_data | src_q;
      OP_RC:   new_d = bus.csr_read_data & ~src_q;
      default: new_d = bus.csr_read_data;
    endcase
  end

  // Set/clear with a zero operand is architecturally a pure read: no write strobe.
  assign do_write_d = (op_q == OP_RW) || (((op_q == OP_RS) || (op_q == OP_RC)) && !src_zero_q);

  assign stall_d = stall_q + PERF_CTR_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      uuid_q     <= '0;
      wid_q      <= '0;
      addr_q     <= '0;
      op_q       <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      rd_q       <= '0;
      old_q      <= '0;
      new_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rsp_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_w) begin
            uuid_q     <= bus.req_uuid;
            wid_q      <= bus.req_wid;
            addr_q     <= bus.req_addr;
            op_q       <= bus.req_op;
            src_q      <= bus.req_src;
            src_zero_q <= bus.req_src_zero;
            rd_q       <= bus.req_rd;
            rd_en_q    <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          old_q   <= bus.csr_read_data;
          new_q   <= new_d;
          rd_en_q <= 1'b0;
          if (do_write_d) begin
            wr_en_q <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_WRITE: begin
          wr_en_q   <= 1'b0;
          rsp_vld_q <= 1'b1;
          state_q   <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          rd_en_q   <= 1'b0;
          wr_en_q   <= 1'b0;
          rsp_vld_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // Counts every refused request cycle, hazard or busy alike; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (bus.req_valid && !req_ready_w) begin
      stall_q <= stall_d;
    end
  end

  assign bus.req_ready        = req_ready_w;
  assign bus.csr_read_enable  = rd_en_q;
  assign bus.csr_read_uuid    = uuid_q;
  assign bus.csr_read_addr    = addr_q;
  assign bus.csr_read_wid     = wid_q;
  assign bus.csr_write_enable = wr_en_q;
  assign bus.csr_write_uuid   = uuid_q;
  assign bus.csr_write_addr   = addr_q;
  assign bus.csr_write_wid    = wid_q;
  assign bus.csr_write_data   = new_q;
  assign bus.rsp_valid        = rsp_vld_q;
  assign bus.rsp_uuid         = uuid_q;
  assign bus.rsp_wid          = wid_q;
  assign bus.rsp_rd           = rd_q;
  assign bus.rsp_data         = old_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.stall_count      = stall_q;

endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Directed bench for csr_rmw_sequencer: hand-computed expectations, immediate assertions.
module tb_csr_rmw_sequencer;

  logic clk;
  logic reset;
  int   n_total;
  int   n_fail;

  csr_rmw_sequencer_if #(
    .NUM_WARPS(4), .NW_BITS(2), .UUID_BITS(44), .CSR_ADDR_BITS(12), .PERF_CTR_BITS(44)
  ) bus ();

  csr_rmw_sequencer #(
    .NUM_WARPS(4), .NW_BITS(2), .UUID_BITS(44), .CSR_ADDR_BITS(12), .PERF_CTR_BITS(44)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle, then scramble the request fields.
  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                       input logic sz, input logic [1:0] wid, input logic [43:0] uuid,
                       input logic [4:0] rd);
    bus.req_op       = op;
    bus.req_addr     = addr;
    bus.req_src      = src;
    bus.req_src_zero = sz;
    bus.req_wid      = wid;
    bus.req_uuid     = uuid;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid    = 1'b0;
    bus.req_src      = 32'hFFFF_FFFF;
    bus.req_uuid     = '0;
    bus.req_rd       = '0;
    bus.req_addr     = 12'h7FF;
    bus.req_op       = 2'b00;
  endtask

  initial begin
    n_total = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_uuid = '0; bus.req_wid = '0; bus.req_addr = '0;
    bus.req_op = '0; bus.req_src = '0; bus.req_src_zero = 1'b0; bus.req_rd = '0;
    bus.fpu_pending = '0; bus.csr_read_data = '0; bus.rsp_ready = 1'b1;

    // reset state
    #3;
    chk("rst_busy",    64'(bus.busy), 64'd0);
    chk("rst_ready",   64'(bus.req_ready), 64'd1);
    chk("rst_rden",    64'(bus.csr_read_enable), 64'd0);
    chk("rst_wren",    64'(bus.csr_write_enable), 64'd0);
    chk("rst_rspv",    64'(bus.rsp_valid), 64'd0);
    chk("rst_rspdata", 64'(bus.rsp_data), 64'd0);
    chk("rst_stall",   64'(bus.stall_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // RW 0x340 <- DEADBEEF, old 12345678
    bus.csr_read_data = 32'h1234_5678;
    issue(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 2'd0, 44'h111, 5'd5);
    chk("rw_rden",   64'(bus.csr_read_enable), 64'd1);
    chk("rw_rdaddr", 64'(bus.csr_read_addr), 64'h340);
    chk("rw_rduuid", 64'(bus.csr_read_uuid), 64'h111);
    chk("rw_busy",   64'(bus.busy), 64'd1);
    chk("rw_noready",64'(bus.req_ready), 64'd0);
    tick();
    chk("rw_wren",   64'(bus.csr_write_enable), 64'd1);
    chk("rw_wrdata", 64'(bus.csr_write_data), 64'hDEAD_BEEF);
    chk("rw_wraddr", 64'(bus.csr_write_addr), 64'h340);
    chk("rw_rden0",  64'(bus.csr_read_enable), 64'd0);
    bus.csr_read_data = 32'hDEAD_BEEF;
    tick();
    chk("rw_rspv",   64'(bus.rsp_valid), 64'd1);
    chk("rw_rspdata",64'(bus.rsp_data), 64'h1234_5678);
    chk("rw_rspuuid",64'(bus.rsp_uuid), 64'h111);
    chk("rw_rsprd",  64'(bus.rsp_rd), 64'd5);
    chk("rw_wren0",  64'(bus.csr_write_enable), 64'd0);
    tick();
    chk("rw_idle_rspv", 64'(bus.rsp_valid), 64'd0);
    chk("rw_idle_ready",64'(bus.req_ready), 64'd1);

    // RS src=0F old=F0 -> write FF
    bus.csr_read_data = 32'h0000_00F0;
    issue(2'b10, 12'h341, 32'h0000_000F, 1'b0, 2'd1, 44'h222, 5'd6);
    tick();
    chk("rs_wren",   64'(bus.csr_write_enable), 64'd1);
    chk("rs_wrdata", 64'(bus.csr_write_data), 64'hFF);
    tick();
    chk("rs_rspdata",64'(bus.rsp_data), 64'hF0);
    chk("rs_rspwid", 64'(bus.rsp_wid), 64'd1);
    tick();

    // RS with src_zero -> read only, rsp at accept+2
    issue(2'b10, 12'h341, 32'h0000_0000, 1'b1, 2'd0, 44'h223, 5'd6);
    chk("rsz_rden",  64'(bus.csr_read_enable), 64'd1);
    tick();
    chk("rsz_nowr",  64'(bus.csr_write_enable), 64'd0);
    chk("rsz_rspv",  64'(bus.rsp_valid), 64'd1);
    chk("rsz_rspdata",64'(bus.rsp_data), 64'hF0);
    tick();

    // RC src=3 old=7 -> write 4
    bus.csr_read_data = 32'h7;
    issue(2'b11, 12'h342, 32'h3, 1'b0, 2'd3, 44'h333, 5'd7);
    tick();
    chk("rc_wren",   64'(bus.csr_write_enable), 64'd1);
    chk("rc_wrdata", 64'(bus.csr_write_data), 64'h4);
    chk("rc_wrwid",  64'(bus.csr_write_wid), 64'd3);
    tick();
    chk("rc_rspdata",64'(bus.rsp_data), 64'h7);
    tick();

    // op 00 -> read only
    bus.csr_read_data = 32'h0000_CAFE;
    issue(2'b00, 12'h300, 32'h1234, 1'b0, 2'd0, 44'h444, 5'd8);
    tick();
    chk("ro_nowr",   64'(bus.csr_write_enable), 64'd0);
    chk("ro_rspv",   64'(bus.rsp_valid), 64'd1);
    chk("ro_rspdata",64'(bus.rsp_data), 64'hCAFE);
    tick();
    chk("pre_hz_stall", 64'(bus.stall_count), 64'd0);

    // FCSR hazard on wid 2 for 5 cycles
    bus.fpu_pending = 4'b0100;
    bus.req_addr = 12'h003; bus.req_wid = 2'd2; bus.req_op = 2'b01;
    bus.req_src = 32'h5; bus.req_src_zero = 1'b0; bus.req_uuid = 44'h555; bus.req_rd = 5'd9;
    bus.req_valid = 1'b1;
    #1;
    chk("hz_block", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("hz_still_block", 64'(bus.req_ready), 64'd0);
    chk("hz_stall5", 64'(bus.stall_count), 64'd5);
    chk("hz_not_busy", 64'(bus.busy), 64'd0);
    bus.fpu_pending = 4'b0000;
    #1;
    chk("hz_release_comb", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("hz_acc_rdaddr", 64'(bus.csr_read_addr), 64'h003);
    chk("hz_acc_rdwid",  64'(bus.csr_read_wid), 64'd2);
    chk("hz_acc_stall",  64'(bus.stall_count), 64'd5);
    tick(); tick(); tick();
    chk("hz_done", 64'(bus.busy), 64'd0);

    // same FCSR on wid 1 is not blocked by wid 2's pending op
    bus.fpu_pending = 4'b0100;
    bus.req_wid = 2'd1; bus.req_addr = 12'h003;
    #1;
    chk("hz_other_wid", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("hz_other_acc", 64'(bus.csr_read_wid), 64'd1);
    tick(); tick(); tick();
    bus.fpu_pending = 4'b0000;

    // rsp_ready held low for 3 cycles
    bus.csr_read_data = 32'h0000_ABCD;
    issue(2'b00, 12'h300, 32'h0, 1'b0, 2'd0, 44'h55, 5'd7);
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_op = 2'b00; bus.req_addr = 12'h340; bus.req_wid = 2'd0;
    bus.req_uuid = 44'h66; bus.req_rd = 5'd9; bus.req_valid = 1'b1;
    bus.csr_read_data = 32'h0000_9999;
    #1;
    chk("bp_rspv", 64'(bus.rsp_valid), 64'd1);
    chk("bp_noready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_v",    64'(bus.rsp_valid), 64'd1);
      chk("bp_hold_data", 64'(bus.rsp_data), 64'hABCD);
      chk("bp_hold_uuid", 64'(bus.rsp_uuid), 64'h55);
    end
    chk("bp_stall8", 64'(bus.stall_count), 64'd8);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_done", 64'(bus.rsp_valid), 64'd0);
    chk("bp_ready",    64'(bus.req_ready), 64'd1);
    chk("bp_stall9",   64'(bus.stall_count), 64'd9);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_acc_uuid", 64'(bus.csr_read_uuid), 64'h66);
    tick();
    chk("bp2_rspdata", 64'(bus.rsp_data), 64'h9999);
    chk("bp2_rsprd",   64'(bus.rsp_rd), 64'd9);
    tick();

    // reset during WRITE
    bus.csr_read_data = 32'h1;
    issue(2'b01, 12'h340, 32'h0000_AAAA, 1'b0, 2'd0, 44'h77, 5'd1);
    tick();
    chk("mr_wren", 64'(bus.csr_write_enable), 64'd1);
    reset = 1'b1;
    #1;
    chk("mr_wren0", 64'(bus.csr_write_enable), 64'd0);
    chk("mr_busy0", 64'(bus.busy), 64'd0);
    chk("mr_rspv0", 64'(bus.rsp_valid), 64'd0);
    chk("mr_stall0",64'(bus.stall_count), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    issue(2'b10, 12'h340, 32'h0000_0100, 1'b0, 2'd2, 44'h88, 5'd2);
    chk("mr_next_rden", 64'(bus.csr_read_enable), 64'd1);
    tick();
    chk("mr_next_wrdata", 64'(bus.csr_write_data), 64'h101);
    tick();
    chk("mr_next_rspdata", 64'(bus.rsp_data), 64'h1);
    tick();
    chk("mr_next_idle", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/csr_rmw_sequencer.md
Name: csr_rmw_sequencer

Overview:
Sequences CSR instructions (CSRRW/CSRRS/CSRRC) against the core's CSR data file. It accepts one request at a time from the issue stage and performs read, modify, optional write-back and response as separate states. Requests that touch FP flag CSRs are blocked while that warp has FPU operations in flight. It sits between the issue/dispatch stage and the CSR data file, and returns the old CSR value to commit.

Parameters:
NUM_WARPS, 4, warps per core
NW_BITS, 2, warp-id width (clog2 of NUM_WARPS, minimum 1)
UUID_BITS, 44, instruction trace-id width
CSR_ADDR_BITS, 12, CSR address width
PERF_CTR_BITS, 44, stall counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted this cycle when high with req_valid
req_uuid  in  UUID_BITS  trace id
req_wid  in  NW_BITS  warp id
req_addr  in  CSR_ADDR_BITS  CSR address
req_op  in  2  operation: 00 read-only, 01 RW, 10 RS (set), 11 RC (clear)
req_src  in  32  rs1 value or zero-extended immediate
req_src_zero  in  1  rs1==x0 or imm==0 (decode flag)
req_rd  in  5  destination register, passed through
fpu_pending  in  NUM_WARPS  per-warp FPU ops in flight
csr_read_enable  out  1  read strobe to CSR file
csr_read_uuid  out  UUID_BITS  trace id for the read
csr_read_addr  out  CSR_ADDR_BITS  read address
csr_read_wid  out  NW_BITS  read warp id
csr_read_data  in  32  combinational read data, valid in the same cycle as csr_read_enable
csr_write_enable  out  1  write strobe
csr_write_uuid  out  UUID_BITS  trace id for the write
csr_write_addr  out  CSR_ADDR_BITS  write address
csr_write_wid  out  NW_BITS  write warp id
csr_write_data  out  32  value to write
rsp_valid  out  1  response valid
rsp_ready  in  1  commit accepts response
rsp_uuid  out  UUID_BITS  latched trace id
rsp_wid  out  NW_BITS  latched warp id
rsp_rd  out  5  latched destination register
rsp_data  out  32  old CSR value
busy  out  1  state != IDLE
stall_count  out  PERF_CTR_BITS  cycles with req_valid && !req_ready

Behaviour:
- Reset (asynchronous): state=IDLE, all latched fields=0, stall_count=0; every output is 0 except req_ready, which follows the IDLE rule below.
- States: IDLE, READ, WRITE, RESP.
- Hazard: hz = (req_addr==0x001 FFLAGS || req_addr==0x003 FCSR) && fpu_pending[req_wid]. FRM (0x002) is never blocked.
- IDLE:
  - req_ready = !hz.
  - On req_valid && req_ready: latch uuid, wid, addr, op, src, src_zero, rd; go to READ.
- READ (1 cycle):
  - csr_read_enable=1, driven with the latched addr/wid/uuid.
  - Capture csr_read_data into old_r.
  - Compute new_r: RW = src; RS = old | src; RC = old & ~src; op 00 = old.
  - do_write = (op==RW) || ((op==RS || op==RC) && !src_zero).
  - Next state: WRITE if do_write, else RESP.
- WRITE (1 cycle):
  - csr_write_enable=1 with csr_write_data=new_r and the latched addr/wid/uuid.
  - Go to RESP.
  - Exactly one write per accepted request with do_write set; no write otherwise.
- RESP:
  - rsp_valid=1, rsp_data=old_r, plus the latched uuid/wid/rd.
  - Hold all response fields stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE.
- Latency and throughput:
  - Accept to rsp_valid: 2 cycles without a write, 3 cycles with a write.
  - Next accept is at the earliest the cycle after the response handshake (req_ready is low in all non-IDLE states).
  - Back-to-back RW requests complete one per 4 cycles with rsp_ready tied high.
- Ordering: RW with rd==x0 still reads. Reads are side-effect-free in the CSR file; rsp_data is simply discarded downstream.
- stall_count:
  - Increments by 1 in every cycle with req_valid && !req_ready, whether caused by a busy state or a hazard.
  - Wraps modulo 2^PERF_CTR_BITS.
- Reset asserted mid-operation: state returns to IDLE immediately and any WRITE strobe drops the same instant. The request is lost; issue must replay it after reset.
- fpu_pending deasserting while a request is stalled: req_ready rises in the same cycle (combinational).
- Latched fields do not change outside the IDLE accept, so req_* may change freely after acceptance.

Test Plan:
- Reset, then RW addr 0x340 src=0xDEADBEEF with CSR holding 0x12345678 -> READ at cycle+1, WRITE of 0xDEADBEEF at cycle+2, rsp_data=0x12345678 at cycle+3.
- RS src=0x0F, src_zero=0, old=0xF0 -> write 0xFF; RS with src_zero=1 -> no csr_write_enable, rsp_valid at accept+2.
- RC src=0x3, old=0x7 -> write 0x4; op 00 -> read only, rsp_data=old.
- FCSR request wid=2 with fpu_pending=4'b0100 held 5 cycles -> req_ready=0 and stall_count+=5; pending drops -> accepted the same cycle. The same request with wid=1 is accepted immediately.
- rsp_ready low for 3 cycles in RESP -> rsp_data/uuid stable, next req_valid stalls, stall_count counts those cycles.
- Assert reset while in WRITE -> csr_write_enable=0 at once, busy=0, rsp_valid=0; the next request sequences normally.
